// File: rtl/bus_ctrl_pkg.sv
// Shared types and helpers for the CPU bus master: FSM states, mode encoding
// and the per-beat address increment.
package bus_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // Bytes per bus beat; the address advances by this amount on every accept.
    function automatic int unsigned byte_incr(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/bus_src_mux.sv
// N-to-1 selector over a flattened source vector; unmatched select values
// (possible when N is not a power of two) yield all zeros.
module bus_src_mux #(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [N*W-1:0]   src,
    output logic [W-1:0]     dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                dout = src[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/bus_master_ctrl.sv
// CPU bus master: picks address/write-data sources, then runs single or
// incrementing-burst read/write transactions with a per-beat timeout.
module bus_master_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int N_ADDR_SRC     = 8,
    parameter int N_DATA_SRC     = 4,
    parameter int BURST_W        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start_transaction,
    input  logic                             mode,
    input  logic [$clog2(N_ADDR_SRC)-1:0]    addr_cs,
    input  logic [$clog2(N_DATA_SRC)-1:0]    data_cs,
    input  logic [N_ADDR_SRC*ADDR_WIDTH-1:0] addr_src,
    input  logic [N_DATA_SRC*DATA_WIDTH-1:0] data_src,
    input  logic [BURST_W-1:0]               burst_len,
    output logic                             busy,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             rdata_valid,
    output logic                             write_done,
    output logic                             timeout_err,
    output logic [ADDR_WIDTH-1:0]            BUS_addr,
    output logic [DATA_WIDTH-1:0]            BUS_wdata,
    input  logic [DATA_WIDTH-1:0]            BUS_rdata,
    output logic                             BUS_valid,
    input  logic                             BUS_wready,
    output logic                             BUS_rready,
    input  logic                             BUS_rvalid,
    output logic                             BUS_mode
);

    localparam int AS_W   = $clog2(N_ADDR_SRC);
    localparam int DS_W   = $clog2(N_DATA_SRC);
    localparam int WCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX =
        WCNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(byte_incr(DATA_WIDTH));

    state_t                  state;
    logic [BURST_W-1:0]      bcnt;
    logic [WCNT_W-1:0]       wcnt;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    wr_acc;
    logic                    rd_acc;
    logic                    beat_acc;
    logic                    last_beat;
    logic                    timeout_hit;

    bus_src_mux #(.N(N_ADDR_SRC), .W(ADDR_WIDTH), .SEL_W(AS_W)) u_addr_mux (
        .sel  (addr_cs),
        .src  (addr_src),
        .dout (sel_addr)
    );

    bus_src_mux #(.N(N_DATA_SRC), .W(DATA_WIDTH), .SEL_W(DS_W)) u_data_mux (
        .sel  (data_cs),
        .src  (data_src),
        .dout (sel_data)
    );

    assign wr_acc      = (state == WR) && BUS_valid && BUS_wready;
    assign rd_acc      = (state == RD) && BUS_rvalid && BUS_rready;
    assign beat_acc    = wr_acc || rd_acc;
    assign last_beat   = (bcnt == '0);
    // An accept on the limit cycle takes priority over the timeout.
    assign timeout_hit = TO_EN && (wcnt == WCNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bcnt        <= '0;
            wcnt        <= '0;
            busy        <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            write_done  <= 1'b0;
            timeout_err <= 1'b0;
            BUS_addr    <= '0;
            BUS_wdata   <= '0;
            BUS_valid   <= 1'b0;
            BUS_rready  <= 1'b0;
            BUS_mode    <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            write_done  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_transaction) begin
                        BUS_addr   <= sel_addr;
                        BUS_wdata  <= sel_data;
                        BUS_mode   <= mode;
                        bcnt       <= burst_len;
                        wcnt       <= '0;
                        busy       <= 1'b1;
                        BUS_valid  <= 1'b1;
                        BUS_rready <= (mode == MODE_READ);
                        state      <= (mode == MODE_WRITE) ? WR : RD;
                    end
                end
                WR, RD: begin
                    if (beat_acc) begin
                        BUS_addr <= BUS_addr + ADDR_INC;
                        wcnt     <= '0;
                        if (state == WR) begin
                            // Write data is re-sampled live so upstream can stream.
                            BUS_wdata <= sel_data;
                        end else begin
                            rdata       <= BUS_rdata;
                            rdata_valid <= 1'b1;
                        end
                        if (last_beat) begin
                            write_done <= (state == WR);
                            state      <= IDLE;
                            busy       <= 1'b0;
                            BUS_valid  <= 1'b0;
                            BUS_rready <= 1'b0;
                        end else begin
                            bcnt <= bcnt - 1'b1;
                        end
                    end else if (timeout_hit) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                        BUS_valid   <= 1'b0;
                        BUS_rready  <= 1'b0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    BUS_valid  <= 1'b0;
                    BUS_rready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Self-checking bench for bus_master_ctrl: directed scenarios plus randomized
// transactions compared against a beat-level reference model.
module tb_bus_master_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NA = 8;
    localparam int ND = 3;
    localparam int BW = 4;
    localparam int T  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_transaction;
    logic              mode;
    logic [2:0]        addr_cs;
    logic [1:0]        data_cs;
    logic [NA*AW-1:0]  addr_src;
    logic [ND*DW-1:0]  data_src;
    logic [BW-1:0]     burst_len;
    logic              busy;
    logic [DW-1:0]     rdata;
    logic              rdata_valid;
    logic              write_done;
    logic              timeout_err;
    logic [AW-1:0]     BUS_addr;
    logic [DW-1:0]     BUS_wdata;
    logic [DW-1:0]     BUS_rdata;
    logic              BUS_valid;
    logic              BUS_wready;
    logic              BUS_rready;
    logic              BUS_rvalid;
    logic              BUS_mode;

    bus_master_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_ADDR_SRC(NA), .N_DATA_SRC(ND),
        .BURST_W(BW), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_transaction(start_transaction), .mode(mode),
        .addr_cs(addr_cs), .data_cs(data_cs), .addr_src(addr_src), .data_src(data_src),
        .burst_len(burst_len), .busy(busy), .rdata(rdata), .rdata_valid(rdata_valid),
        .write_done(write_done), .timeout_err(timeout_err), .BUS_addr(BUS_addr),
        .BUS_wdata(BUS_wdata), .BUS_rdata(BUS_rdata), .BUS_valid(BUS_valid),
        .BUS_wready(BUS_wready), .BUS_rready(BUS_rready), .BUS_rvalid(BUS_rvalid),
        .BUS_mode(BUS_mode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-beat slave wait cycles and read data, set by each scenario.
    int          w_tab [16];
    logic [31:0] r_tab [16];
    logic        stray_start = 1'b0;

    // Observations gathered by do_txn.
    logic [31:0] obs_addr[$];
    logic [31:0] obs_wdata[$];
    logic [31:0] obs_rdata[$];
    logic [31:0] exp_wdata[$];
    int          n_wdone, n_terr, n_rvld, end_cnt;
    bit          ended;
    logic        first_busy, first_valid, first_mode, first_rready, end_vr;

    function automatic logic [31:0] sel_data(input int cs);
        return (cs < ND) ? data_src[cs*DW +: DW] : 32'h0;
    endfunction

    // Beats completed before the first beat whose wait reaches the timeout.
    function automatic int model_ok(input int bl);
        int n = 0;
        for (int i = 0; i <= bl; i++) begin
            if (w_tab[i] >= T) break;
            n++;
        end
        return n;
    endfunction

    // Negedge index (1 = first negedge after the start edge) where busy is seen low.
    function automatic int model_end(input int bl, input int ok);
        int s = 0;
        for (int i = 0; i < ok; i++) s += w_tab[i] + 1;
        if (ok <= bl) s += T;
        return s + 1;
    endfunction

    // Starts a transaction at a negedge and acts as the slave until busy drops.
    task automatic do_txn(input logic m, input logic [31:0] base, input int acs,
                          input int dcs, input int bl, input logic [31:0] d0);
        int beat = 0;
        int wc = 0;
        int cnt = 1;
        obs_addr.delete(); obs_wdata.delete(); obs_rdata.delete(); exp_wdata.delete();
        n_wdone = 0; n_terr = 0; n_rvld = 0; end_cnt = 0; ended = 0;
        for (int i = 0; i < NA; i++) addr_src[i*AW +: AW] = $urandom;
        addr_src[acs*AW +: AW] = base;
        for (int i = 0; i < ND; i++) data_src[i*DW +: DW] = $urandom;
        if (dcs < ND) data_src[dcs*DW +: DW] = d0;
        exp_wdata.push_back(sel_data(dcs));
        addr_cs = 3'(acs); data_cs = 2'(dcs); mode = m; burst_len = 4'(bl);
        start_transaction = 1'b1;
        @(negedge clk);
        start_transaction = 1'b0;
        first_busy = busy; first_valid = BUS_valid; first_mode = BUS_mode; first_rready = BUS_rready;
        while (cnt < 200) begin
            if (rdata_valid) begin n_rvld++; obs_rdata.push_back(rdata); end
            if (write_done) n_wdone++;
            if (timeout_err) n_terr++;
            if (!busy) begin
                ended = 1; end_cnt = cnt; end_vr = BUS_valid | BUS_rready;
                break;
            end
            start_transaction = stray_start;
            mode = ~m;
            addr_cs = 3'($urandom_range(0, NA-1));
            for (int i = 0; i < ND; i++) data_src[i*DW +: DW] = $urandom;
            BUS_wready = m ? 1'b0 : 1'($urandom_range(0, 1));
            BUS_rvalid = m ? 1'($urandom_range(0, 1)) : 1'b0;
            BUS_rdata  = $urandom;
            if (BUS_valid && beat < 16 && beat <= bl && wc == w_tab[beat]) begin
                obs_addr.push_back(BUS_addr);
                obs_wdata.push_back(BUS_wdata);
                if (m) begin
                    BUS_wready = 1'b1;
                    exp_wdata.push_back(sel_data(dcs));
                end else begin
                    BUS_rvalid = 1'b1;
                    BUS_rdata  = r_tab[beat];
                end
                beat++; wc = 0;
            end else begin
                wc++;
            end
            @(negedge clk);
            cnt++;
        end
        start_transaction = 1'b0; BUS_wready = 1'b0; BUS_rvalid = 1'b0; mode = 1'b0;
    endtask

    task automatic fill_waits(input int lo, input int hi);
        for (int i = 0; i < 16; i++) begin
            w_tab[i] = $urandom_range(lo, hi);
            r_tab[i] = $urandom;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, rdata_valid, write_done, timeout_err, BUS_valid, BUS_rready, BUS_mode} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000000",
                     {busy, rdata_valid, write_done, timeout_err, BUS_valid, BUS_rready, BUS_mode});
        end
        checks++;
        if ({BUS_addr, BUS_wdata, rdata} !== 96'b0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h want 0", BUS_addr, BUS_wdata, rdata);
        end
    endtask

    task automatic test_single_write();
        fill_waits(0, 0);
        w_tab[0] = 2;
        do_txn(1'b1, 32'h1000, 3, 1, 0, 32'hDEADBEEF);
        checks++;
        if (!(first_busy && first_valid && first_mode)) begin
            errors++;
            $display("FAIL sw_start got busy=%b valid=%b mode=%b want 111", first_busy, first_valid, first_mode);
        end
        checks++;
        if (obs_addr.size() != 1 || obs_addr[0] !== 32'h1000 || obs_wdata[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_beat got n=%0d addr=%h data=%h want 1 00001000 deadbeef",
                     obs_addr.size(), obs_addr.size() ? obs_addr[0] : 32'hx, obs_wdata.size() ? obs_wdata[0] : 32'hx);
        end
        checks++;
        if (n_wdone != 1 || n_terr != 0 || !ended || end_cnt != 4) begin
            errors++;
            $display("FAIL sw_done got wdone=%0d terr=%0d ended=%0d end=%0d want 1 0 1 4",
                     n_wdone, n_terr, ended, end_cnt);
        end
    endtask

    task automatic test_read_burst();
        fill_waits(0, 0);
        w_tab[0] = 1; w_tab[1] = 0; w_tab[2] = 2; w_tab[3] = 1;
        for (int i = 0; i < 4; i++) r_tab[i] = 32'hA0 + 32'(i);
        do_txn(1'b0, 32'h2000, 5, 0, 3, 32'h0);
        checks++;
        if (n_rvld != 4 || n_terr != 0 || n_wdone != 0 || !first_rready || first_mode !== 1'b0) begin
            errors++;
            $display("FAIL rb_counts got rvld=%0d terr=%0d wdone=%0d rready=%b mode=%b want 4 0 0 1 0",
                     n_rvld, n_terr, n_wdone, first_rready, first_mode);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= obs_addr.size() || i >= obs_rdata.size() ||
                obs_addr[i] !== 32'h2000 + 32'(4*i) || obs_rdata[i] !== 32'hA0 + 32'(i)) begin
                errors++;
                $display("FAIL rb_beat%0d got addr=%h rdata=%h want %h %h", i,
                         (i < obs_addr.size()) ? obs_addr[i] : 32'hx,
                         (i < obs_rdata.size()) ? obs_rdata[i] : 32'hx,
                         32'h2000 + 32'(4*i), 32'hA0 + 32'(i));
            end
        end
    endtask

    task automatic test_wrap();
        fill_waits(0, 2);
        do_txn(1'b1, 32'hFFFFFFFC, 2, 2, 1, 32'h12345678);
        checks++;
        if (obs_addr.size() != 2 || obs_addr[0] !== 32'hFFFFFFFC || obs_addr[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr got n=%0d a1=%h want 2 00000000", obs_addr.size(),
                     (obs_addr.size() > 1) ? obs_addr[1] : 32'hx);
        end
        checks++;
        if (n_terr != 0 || n_wdone != 1) begin
            errors++;
            $display("FAIL wrap_done got terr=%0d wdone=%0d want 0 1", n_terr, n_wdone);
        end
    endtask

    task automatic test_timeout();
        fill_waits(0, 0);
        w_tab[0] = 100;
        do_txn(1'b0, 32'h4000, 1, 0, 0, 32'h0);
        checks++;
        if (n_terr != 1 || n_rvld != 0 || !ended || end_cnt != T + 1 || end_vr !== 1'b0) begin
            errors++;
            $display("FAIL to_read got terr=%0d rvld=%0d end=%0d vr=%b want 1 0 %0d 0",
                     n_terr, n_rvld, end_cnt, end_vr, T + 1);
        end
        w_tab[0] = T - 1;
        do_txn(1'b1, 32'h4100, 1, 0, 0, 32'h55AA55AA);
        checks++;
        if (n_terr != 0 || n_wdone != 1 || end_cnt != T + 1 || obs_wdata.size() != 1 || obs_wdata[0] !== 32'h55AA55AA) begin
            errors++;
            $display("FAIL to_limit_accept got terr=%0d wdone=%0d end=%0d want 0 1 %0d",
                     n_terr, n_wdone, end_cnt, T + 1);
        end
    endtask

    task automatic test_out_of_range();
        fill_waits(0, 1);
        do_txn(1'b1, 32'h5000, 7, 3, 2, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= obs_wdata.size() || obs_wdata[i] !== 32'h0) begin
                errors++;
                $display("FAIL oor_wdata%0d got %h want 00000000", i,
                         (i < obs_wdata.size()) ? obs_wdata[i] : 32'hx);
            end
        end
    endtask

    task automatic test_busy_ignore();
        fill_waits(0, 2);
        stray_start = 1'b1;
        do_txn(1'b1, 32'h6000, 4, 0, 3, 32'hCAFE0000);
        stray_start = 1'b0;
        checks++;
        if (obs_addr.size() != 4 || obs_addr[3] !== 32'h600C || n_wdone != 1 || first_mode !== 1'b1) begin
            errors++;
            $display("FAIL busy_burst got n=%0d wdone=%0d want 4 1", obs_addr.size(), n_wdone);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || BUS_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_stray got busy=%b valid=%b want 0 0", busy, BUS_valid);
        end
    endtask

    task automatic test_reset_mid();
        addr_src[0 +: AW] = 32'h3000;
        data_src[0 +: DW] = 32'h0BADF00D;
        addr_cs = 3'd0; data_cs = 2'd0; mode = 1'b1; burst_len = 4'd7;
        start_transaction = 1'b1;
        @(negedge clk);
        start_transaction = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, BUS_valid, BUS_rready, BUS_mode, write_done, timeout_err} !== 6'b0 ||
            BUS_addr !== 32'h0 || BUS_wdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_async got busy=%b valid=%b addr=%h wdata=%h want 0 0 0 0",
                     busy, BUS_valid, BUS_addr, BUS_wdata);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_noerr got terr=%b busy=%b want 0 0", timeout_err, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        fill_waits(0, 1);
        do_txn(1'b0, 32'h7000, 6, 1, 1, 32'h0);
        checks++;
        if (n_rvld != 2 || n_terr != 0 || obs_rdata.size() != 2 || obs_rdata[1] !== r_tab[1] ||
            obs_addr.size() != 2 || obs_addr[1] !== 32'h7004) begin
            errors++;
            $display("FAIL rst_after got rvld=%0d terr=%0d want 2 0", n_rvld, n_terr);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            logic        m;
            logic [31:0] base;
            int          bl, acs, dcs, ok;
            bit          to;
            m    = 1'($urandom_range(0, 1));
            base = $urandom;
            bl   = $urandom_range(0, 3);
            acs  = $urandom_range(0, NA-1);
            dcs  = $urandom_range(0, 3);
            fill_waits(0, 3);
            if ($urandom_range(0, 4) == 0) w_tab[$urandom_range(0, bl)] = $urandom_range(T-1, T+2);
            do_txn(m, base, acs, dcs, bl, $urandom);
            ok = model_ok(bl);
            to = (ok <= bl);
            checks++;
            if (!ended || end_cnt != model_end(bl, ok) || first_mode !== m) begin
                errors++;
                $display("FAIL rnd%0d_timing got end=%0d mode=%b want %0d %b", it, end_cnt, first_mode,
                         model_end(bl, ok), m);
            end
            checks++;
            if (n_terr != int'(to) || n_wdone != int'(m && !to) || n_rvld != (m ? 0 : ok)) begin
                errors++;
                $display("FAIL rnd%0d_pulses got terr=%0d wdone=%0d rvld=%0d want %0d %0d %0d", it,
                         n_terr, n_wdone, n_rvld, int'(to), int'(m && !to), m ? 0 : ok);
            end
            checks++;
            if (obs_addr.size() != ok) begin
                errors++;
                $display("FAIL rnd%0d_beats got %0d want %0d", it, obs_addr.size(), ok);
            end else begin
                for (int i = 0; i < ok; i++) begin
                    if (obs_addr[i] !== base + 32'(4*i) ||
                        (m && obs_wdata[i] !== exp_wdata[i]) ||
                        (!m && (i >= obs_rdata.size() || obs_rdata[i] !== r_tab[i]))) begin
                        errors++;
                        $display("FAIL rnd%0d_beat%0d got addr=%h wdata=%h want %h %h", it, i,
                                 obs_addr[i], obs_wdata[i], base + 32'(4*i), exp_wdata[i]);
                        break;
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start_transaction = 1'b0; mode = 1'b0; addr_cs = '0; data_cs = '0;
        addr_src = '0; data_src = '0; burst_len = '0;
        BUS_rdata = '0; BUS_wready = 1'b0; BUS_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_read_burst();
        test_wrap();
        test_timeout();
        test_out_of_range();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end

endmodule
